broadcast_tree_scatter: RTL and testbench
=========================================

Name: broadcast_tree_scatter

Overview:
- Controller-to-PE distribution tree, the downstream counterpart of the PE-to-controller max/consensus reduction trees.
- Accepts one word plus a PE target mask per handshake and fans it out through LOG_NUM_PE registered binary-tree levels.
- Each targeted PE receives the word on its own valid/ready port.
- Used to push X-Drop control words (tile start, reference offset, band limits) to all PEs or to a subset.

Parameters:
- PE_WIDTH, 16, data word width.
- NUM_PE, 4, number of PE leaf ports; must equal 2**LOG_NUM_PE.
- LOG_NUM_PE, 2, tree depth; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  source word valid.
- in_ready  output  1  tree can accept a word this cycle.
- in_data  input  PE_WIDTH  word to distribute.
- in_mask  input  NUM_PE  target PEs; bit p selects PE p.
- out_valid  output  NUM_PE  per-PE valid.
- out_data  output  PE_WIDTH x NUM_PE  per-PE data; unpacked array, index 0 to NUM_PE-1.
- pe_ready  input  NUM_PE  per-PE ready.
- done  output  1  one-cycle pulse: all targeted PEs of the leaf-stage word have accepted it.
- idle  output  1  no word in flight at any level.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All level valid bits, masks and data registers clear.
  - out_valid=0, out_data=0, done=0, idle=1, in_ready=1.
  - Reset mid-operation drops every in-flight word with no done pulse; it has priority over all other events.
- Structure:
  - Level j (0..LOG_NUM_PE-1) holds 2**(j+1) node registers, each with {data, sub_mask}.
  - Node i at level j loads from parent i/2 at level j-1; level 0 loads from the input.
  - sub_mask of a node is the parent mask restricted to the PE leaves under that node.
  - Node valid = |sub_mask. Nodes with an empty sub_mask load data anyway (don't care) but stay invalid.
  - The last level is the leaf stage: node p is PE p. out_data[p] = leaf data; out_valid[p] = pending[p].
- Leaf pending:
  - pending[p] is loaded from the leaf sub_mask when the leaf stage loads.
  - pending[p] clears on out_valid[p] & pe_ready[p].
  - Each PE handshake is independent; a PE may accept in any cycle.
- Advance:
  - adv = (pending & ~pe_ready) == 0, i.e. the leaf stage is empty or draining completely this cycle.
  - When adv=1 every level shifts one step at once; when adv=0 every level holds (global stall).
  - in_ready = adv (combinational).
- Latency and throughput:
  - Word accepted at edge t is presented at leaves with out_valid from cycle t+LOG_NUM_PE.
  - Throughput is 1 word/cycle when all targeted PEs are ready.
- done:
  - Registered pulse in the cycle after the last pending bit of a word clears.
  - Exactly one pulse per word with a nonzero mask.
- Zero mask: the word is accepted (in_ready honoured) and discarded at level 0. No node is valid, no output, no done.
- in_valid=0 while adv=1: a bubble shifts in.
- idle = no valid node at any level and pending == 0.
- Stability: out_data[p] and out_valid[p] must not change while out_valid[p]=1 and pe_ready[p]=0.
- pe_ready on an untargeted PE is ignored.
- Simultaneous events: a partial PE accept during a stall clears only that PE's pending bit; the remaining PEs keep valid.

Decomposition:
- Shared package: pe_word_t (logic [PE_WIDTH-1:0]), pe_mask_t, and a function that extracts the sub_mask for node i at level j.
- One sub-module, broadcast_tree_node: a data+mask register with load enable and reset. It is instantiated per node through generate, with a parameter for the leaf range.

Test Plan:
- Reset, then one word 0x1234 with mask 4'b1111 and all pe_ready=1 -> all out_valid high at cycle 2 after accept, out_data all 0x1234, done pulse next cycle, idle returns to 1.
- Unicast mask 4'b0100, data 0x00AB -> only out_valid[2] asserts, other PEs stay 0, one done pulse.
- Mask 4'b1111, pe_ready=4'b1011 for 3 cycles then 4'b1111 -> PEs 0, 1 and 3 drop valid after one cycle; PE2 holds 0x1234 stable; in_ready=0 during the stall; done one cycle after PE2 accepts.
- Back-to-back stream 0x0001..0x0008, all masks 4'b1111, all ready -> one word per cycle at the leaves in order, 8 done pulses, in_ready constantly 1.
- Zero mask word between two valid words -> accepted, no out_valid, exactly 2 done pulses in total.
- Assert rst_n=0 for one cycle with two words in flight -> all out_valid=0, idle=1 and in_ready=1 next cycle; no done pulse for the dropped words.

Source files
------------

// File: rtl/broadcast_tree_scatter_pkg.sv
// Shared types and helpers for the controller-to-PE broadcast tree.
// The package constants size the word and mask types used by every node;
// the top-level parameters default to them and must stay in agreement.
package broadcast_tree_scatter_pkg;

  localparam int unsigned PeWidth  = 16;
  localparam int unsigned NumPe    = 4;
  localparam int unsigned LogNumPe = 2;

  typedef logic [PeWidth-1:0] pe_word_t;
  typedef logic [NumPe-1:0]   pe_mask_t;

  // Restrict a mask to the PE leaves that sit under node idx of tree level.
  // Level 0 has two nodes, each covering half of the PEs; the last level has
  // one node per PE.
  function automatic pe_mask_t sub_mask(pe_mask_t m, int unsigned level, int unsigned idx);
    int unsigned span;
    int unsigned lo;
    pe_mask_t    r;
    span = NumPe >> (level + 1);
    lo   = idx * span;
    r    = '0;
    for (int unsigned p = 0; p < NumPe; p++) begin
      if (p >= lo && p < lo + span) begin
        r[p] = m[p];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/broadcast_tree_node.sv
// One register stage of the broadcast tree: a data word plus the sub-mask of
// PE leaves still to be served under this node.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset
//   load_i   - capture parent data and restricted parent mask
//   data_i   - parent data word
//   mask_i   - parent mask (full width, restricted here to this node's leaves)
//   clr_i    - mask bits to drop while holding (leaf handshakes)
//   data_o   - stored data word
//   mask_o   - stored sub-mask
//   valid_o  - node carries a word for at least one PE
module broadcast_tree_node
  import broadcast_tree_scatter_pkg::*;
#(
  parameter int unsigned Level = 0,
  parameter int unsigned Index = 0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load_i,
  input  pe_word_t data_i,
  input  pe_mask_t mask_i,
  input  pe_mask_t clr_i,
  output pe_word_t data_o,
  output pe_mask_t mask_o,
  output logic     valid_o
);

  pe_word_t data_d, data_q;
  pe_mask_t mask_d, mask_q;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (load_i) begin
      // Data loads even for an empty sub-mask; it is a don't-care then.
      data_d = data_i;
      mask_d = sub_mask(mask_i, Level, Index);
    end else begin
      mask_d = mask_q & ~clr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign data_o  = data_q;
  assign mask_o  = mask_q;
  assign valid_o = |mask_q;

endmodule

// File: rtl/broadcast_tree_scatter.sv
// Controller-to-PE distribution tree. One word plus a PE target mask is
// accepted per handshake and fanned out through LOG_NUM_PE registered binary
// levels; the last level holds one node per PE and drives that PE's
// valid/ready port. Any PE still pending and not ready stalls the whole tree.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   in_valid/in_ready     - source handshake; in_ready is the global advance
//   in_data, in_mask      - word to distribute and its target PEs
//   out_valid, out_data   - per-PE word presentation
//   pe_ready              - per-PE accept
//   done                  - registered pulse once a word's last PE has accepted
//   idle                  - nothing in flight anywhere in the tree
module broadcast_tree_scatter
  import broadcast_tree_scatter_pkg::*;
#(
  parameter int unsigned PE_WIDTH   = PeWidth,
  parameter int unsigned NUM_PE     = NumPe,
  parameter int unsigned LOG_NUM_PE = LogNumPe
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PE_WIDTH-1:0] in_data,
  input  logic [NUM_PE-1:0]   in_mask,
  output logic [NUM_PE-1:0]   out_valid,
  output logic [PE_WIDTH-1:0] out_data [NUM_PE],
  input  logic [NUM_PE-1:0]   pe_ready,
  output logic                done,
  output logic                idle
);

  // Nodes are numbered flat: level j starts at 2**(j+1)-2.
  localparam int unsigned NumNodes = 2 * NUM_PE - 2;
  localparam int unsigned LeafBase = NUM_PE - 2;

  pe_word_t            node_data  [NumNodes];
  pe_mask_t            node_mask  [NumNodes];
  logic [NumNodes-1:0] node_valid;

  pe_mask_t src_mask;
  logic     adv;
  logic     inner_busy;
  logic     done_d, done_q;

  // A cycle without in_valid shifts an empty mask (bubble) into level 0.
  assign src_mask = in_valid ? in_mask : '0;

  for (genvar j = 0; j < LOG_NUM_PE; j++) begin : g_level
    for (genvar i = 0; i < (2 ** (j + 1)); i++) begin : g_node
      localparam int unsigned Self = (2 ** (j + 1)) - 2 + i;

      pe_word_t par_data;
      pe_mask_t par_mask;
      pe_mask_t clr;

      if (j == 0) begin : g_root
        assign par_data = in_data;
        assign par_mask = src_mask;
      end else begin : g_inner
        localparam int unsigned Parent = (2 ** j) - 2 + i / 2;
        assign par_data = node_data[Parent];
        assign par_mask = node_mask[Parent];
      end

      // Only leaves see PE handshakes; inner nodes move purely on advance.
      if (j == LOG_NUM_PE - 1) begin : g_leaf_clr
        assign clr = pe_ready;
      end else begin : g_inner_clr
        assign clr = '0;
      end

      broadcast_tree_node #(
        .Level (j),
        .Index (i)
      ) u_node (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (adv),
        .data_i  (par_data),
        .mask_i  (par_mask),
        .clr_i   (clr),
        .data_o  (node_data[Self]),
        .mask_o  (node_mask[Self]),
        .valid_o (node_valid[Self])
      );
    end
  end

  // Leaf p is PE p; its mask is exactly that PE's pending bit.
  for (genvar p = 0; p < NUM_PE; p++) begin : g_leaf_out
    assign out_data[p]  = node_data[LeafBase + p];
    assign out_valid[p] = node_valid[LeafBase + p];
  end

  // Advance only when every pending PE is accepting this cycle.
  assign adv      = ((out_valid & ~pe_ready) == '0);
  assign in_ready = adv;

  always_comb begin
    inner_busy = 1'b0;
    for (int unsigned n = 0; n < LeafBase; n++) begin
      inner_busy = inner_busy | node_valid[n];
    end
  end

  assign idle = ~inner_busy & ~(|out_valid);

  // The last pending bits of a word clear exactly when something is pending
  // and the tree advances.
  assign done_d = (|out_valid) & adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_broadcast_tree_scatter.sv
module tb_broadcast_tree_scatter;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_mask;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data [N];
  logic [N-1:0] pe_ready;
  logic         done;
  logic         idle;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int base;

  broadcast_tree_scatter #(
    .PE_WIDTH   (W),
    .NUM_PE     (N),
    .LOG_NUM_PE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pe_ready  (pe_ready),
    .done      (done),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] m,
                       input logic [N-1:0] r);
    in_valid = v;
    in_data  = d;
    in_mask  = m;
    pe_ready = r;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_done", done, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data0", out_data[0], 16'h0000);
    rst_n = 1'b1;

    // Broadcast to all PEs, all ready.
    base = done_cnt;
    drive(1'b1, 16'h1234, 4'b1111, 4'b1111);
    chk("bc_in_ready", in_ready, 1'b1);
    step();
    drive(1'b0, '0, '0, 4'b1111);
    chk("bc_lvl0_no_out", out_valid, 4'b0000);
    chk("bc_busy", idle, 1'b0);
    step();
    chk("bc_out_valid", out_valid, 4'b1111);
    for (int p = 0; p < 4; p++) chk("bc_out_data", out_data[p], 16'h1234);
    chk("bc_no_done_yet", done, 1'b0);
    step();
    chk("bc_drained", out_valid, 4'b0000);
    chk("bc_done", done, 1'b1);
    chk("bc_idle", idle, 1'b1);
    step();
    chk("bc_done_once", done, 1'b0);
    chk("bc_done_cnt", done_cnt - base, 1);

    // Unicast to PE2.
    base = done_cnt;
    drive(1'b1, 16'h00AB, 4'b0100, 4'b1111);
    step();
    drive(1'b0, '0, '0, 4'b1111);
    step();
    chk("uc_out_valid", out_valid, 4'b0100);
    chk("uc_out_data2", out_data[2], 16'h00AB);
    step();
    chk("uc_done", done, 1'b1);
    chk("uc_drained", out_valid, 4'b0000);
    step();
    chk("uc_done_cnt", done_cnt - base, 1);

    // PE2 stalls for three cycles while the others accept.
    base = done_cnt;
    drive(1'b1, 16'h1234, 4'b1111, 4'b1111);
    step();
    drive(1'b0, '0, '0, 4'b1011);
    step();
    chk("st_out_valid", out_valid, 4'b1111);
    chk("st_in_ready_lo", in_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st_hold_valid", out_valid, 4'b0100);
      chk("st_hold_data2", out_data[2], 16'h1234);
      chk("st_hold_in_ready", in_ready, 1'b0);
      chk("st_hold_no_done", done, 1'b0);
    end
    drive(1'b0, '0, '0, 4'b1111);
    chk("st_release_ready", in_ready, 1'b1);
    step();
    chk("st_done", done, 1'b1);
    chk("st_drained", out_valid, 4'b0000);
    step();
    chk("st_done_cnt", done_cnt - base, 1);

    // Back-to-back stream of eight words.
    base = done_cnt;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, W'(k), 4'b1111, 4'b1111);
      chk("bb_in_ready", in_ready, 1'b1);
      step();
      if (k >= 2) begin
        chk("bb_out_valid", out_valid, 4'b1111);
        chk("bb_out_data1", out_data[1], k - 1);
      end
      if (k >= 3) chk("bb_done", done, 1'b1);
    end
    drive(1'b0, '0, '0, 4'b1111);
    step();
    chk("bb_last_data3", out_data[3], 8);
    chk("bb_last_done", done, 1'b1);
    step();
    chk("bb_tail_done", done, 1'b1);
    step();
    chk("bb_done_cnt", done_cnt - base, 8);

    // Zero-mask word between two real words.
    base = done_cnt;
    drive(1'b1, 16'h0011, 4'b1111, 4'b1111);
    step();
    drive(1'b1, 16'h0022, 4'b0000, 4'b1111);
    chk("zm_in_ready", in_ready, 1'b1);
    step();
    chk("zm_first_valid", out_valid, 4'b1111);
    chk("zm_first_data", out_data[0], 16'h0011);
    drive(1'b1, 16'h0033, 4'b0011, 4'b1111);
    step();
    chk("zm_gap_no_valid", out_valid, 4'b0000);
    drive(1'b0, '0, '0, 4'b1111);
    step();
    chk("zm_third_valid", out_valid, 4'b0011);
    chk("zm_third_data", out_data[0], 16'h0033);
    step();
    step();
    chk("zm_done_cnt", done_cnt - base, 2);
    chk("zm_idle", idle, 1'b1);

    // Reset with two words in flight.
    base = done_cnt;
    drive(1'b1, 16'h0AAA, 4'b1111, 4'b0000);
    step();
    drive(1'b1, 16'h0BBB, 4'b1111, 4'b0000);
    step();
    chk("mr_leaf_full", out_valid, 4'b1111);
    chk("mr_stalled", in_ready, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 4'b0000);
    step();
    chk("mr_out_valid", out_valid, 4'b0000);
    chk("mr_idle", idle, 1'b1);
    chk("mr_in_ready", in_ready, 1'b1);
    chk("mr_done", done, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 4'b1111);
    step();
    step();
    step();
    chk("mr_stays_empty", out_valid, 4'b0000);
    chk("mr_done_cnt", done_cnt - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
